// File: rtl/gray_pkg.sv
// Shared constants and reference functions for the Gray-to-binary converter.
// gray2bin is a behavioural reference model; popcount backs the optional step check.
package gray_pkg;

    localparam int GRAY_DEFAULT_WIDTH = 4;

    // Only bits below 'width' are used. The MSB-down running XOR is the binary value.
    function automatic logic [63:0] gray2bin(input logic [63:0] gray, input int width);
        logic [63:0] bin;
        logic        acc;
        bin = '0;
        acc = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (i < width) begin
                acc    = acc ^ gray[i];
                bin[i] = acc;
            end
        end
        return bin;
    endfunction

    function automatic logic [6:0] popcount(input logic [63:0] value);
        logic [6:0] count;
        count = '0;
        for (int i = 0; i < 64; i++) begin
            count = count + 7'(value[i]);
        end
        return count;
    endfunction

endpackage

// File: rtl/gray_to_binary_prefix_xor.sv
// Combinational MSB-down XOR prefix: bin[i] is the XOR of gray[WIDTH-1:i].
// Each bit is an independent reduction, so there is no bit-to-bit chain.
module gray_prefix_xor #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign bin[gi] = ^gray[WIDTH-1:gi];
    end

endmodule

// File: rtl/gray_to_binary.sv
// Registered Gray-to-binary converter, one cycle of latency, one word per cycle.
// Optional Gray step checker (step_err output) enabled by GRAY_TO_BINARY_STEP_CHECK_EN.
module gray_to_binary
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] gray,
    output logic             out_valid,
    output logic [WIDTH-1:0] bin
`ifdef GRAY_TO_BINARY_STEP_CHECK_EN
    ,
    output logic             step_err
`endif
);

    logic [WIDTH-1:0] conv;
    logic             out_valid_reg;
    logic             out_valid_next;
    logic [WIDTH-1:0] bin_reg;
    logic [WIDTH-1:0] bin_next;

    gray_prefix_xor #(
        .WIDTH(WIDTH)
    ) u_prefix (
        .gray(gray),
        .bin (conv)
    );

    // The mux keeps an unqualified (possibly X) gray word away from bin.
    always_comb begin
        out_valid_next = in_valid;
        bin_next       = bin_reg;
        if (in_valid) begin
            bin_next = conv;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            bin_reg       <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            bin_reg       <= bin_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign bin       = bin_reg;

`ifdef GRAY_TO_BINARY_STEP_CHECK_EN
    logic [WIDTH-1:0] prev_gray_reg;
    logic [WIDTH-1:0] prev_gray_next;
    logic             history_reg;
    logic             history_next;
    logic             step_err_reg;
    logic             step_err_next;
    logic [6:0]       diff_count;

    // A legal Gray step changes at most one bit; repeating a word is allowed.
    always_comb begin
        diff_count     = popcount(64'(gray ^ prev_gray_reg));
        step_err_next  = 1'b0;
        prev_gray_next = prev_gray_reg;
        history_next   = history_reg;
        if (in_valid) begin
            step_err_next  = history_reg && (diff_count > 7'd1);
            prev_gray_next = gray;
            history_next   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_gray_reg <= '0;
            history_reg   <= 1'b0;
            step_err_reg  <= 1'b0;
        end else begin
            prev_gray_reg <= prev_gray_next;
            history_reg   <= history_next;
            step_err_reg  <= step_err_next;
        end
    end

    assign step_err = step_err_reg;
`endif

endmodule

// File: tb/tb_gray_to_binary.sv
// Directed bench for gray_to_binary at WIDTH 4, 16 and 1.
// Covers the step checker when GRAY_TO_BINARY_STEP_CHECK_EN is defined.
module tb_gray_to_binary;
    import gray_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv4, ov4, iv16, ov16, iv1, ov1;
    logic [3:0]  g4, b4;
    logic [15:0] g16, b16;
    logic [0:0]  g1, b1;
    logic        se4, se16, se1;

    int n_tests = 0;
    int n_fail  = 0;

    gray_to_binary #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .gray(g4), .out_valid(ov4), .bin(b4)
`ifdef GRAY_TO_BINARY_STEP_CHECK_EN
        , .step_err(se4)
`endif
    );

    gray_to_binary #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .gray(g16), .out_valid(ov16), .bin(b16)
`ifdef GRAY_TO_BINARY_STEP_CHECK_EN
        , .step_err(se16)
`endif
    );

    gray_to_binary #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .gray(g1), .out_valid(ov1), .bin(b1)
`ifdef GRAY_TO_BINARY_STEP_CHECK_EN
        , .step_err(se1)
`endif
    );

`ifndef GRAY_TO_BINARY_STEP_CHECK_EN
    assign se4  = 1'b0;
    assign se16 = 1'b0;
    assign se1  = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  dg [4];
        logic [3:0]  db [4];
        logic [3:0]  bv;
        logic [15:0] bv16;

        dg = '{4'b0000, 4'b0110, 4'b1000, 4'b1111};
        db = '{4'b0000, 4'b0100, 4'b1111, 4'b1010};

        // Reset held with valid traffic present.
        rst_n = 1'b0; iv4 = 1'b1; g4 = 4'b1111;
        iv16 = 1'b0; g16 = '0; iv1 = 1'b0; g1 = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_bin", 64'(b4), 64'h0);
            check("rst_ov", 64'(ov4), 64'h0);
        end
        rst_n = 1'b1;
        tick();
        check("first_bin", 64'(b4), 64'hA);
        check("first_ov", 64'(ov4), 64'h1);

        // Directed back-to-back vectors.
        for (int i = 0; i < 4; i++) begin
            g4 = dg[i];
            tick();
            check($sformatf("dir_bin_%0d", i), 64'(b4), 64'(db[i]));
            check($sformatf("dir_ov_%0d", i), 64'(ov4), 64'h1);
        end

        // Idle hold with X on gray.
        g4 = 4'b1000;
        tick();
        check("idle_pre", 64'(b4), 64'hF);
        iv4 = 1'b0; g4 = 'x;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_bin", 64'(b4), 64'hF);
            check("idle_ov", 64'(ov4), 64'h0);
            check("idle_known", 64'($isunknown(b4)), 64'h0);
            check("idle_serr", 64'(se4), 64'h0);
        end

        // Exhaustive WIDTH=4: drive the Gray code of each binary value.
        iv4 = 1'b1;
        for (int b = 0; b < 16; b++) begin
            bv = 4'(b);
            g4 = bv ^ (bv >> 1);
            check("pkg_g2b", gray2bin(64'(g4), 4), 64'(bv));
            tick();
            check($sformatf("exh_bin_%0d", b), 64'(b4), 64'(bv));
            check("exh_ov", 64'(ov4), 64'h1);
        end

        // Mid-stream reset between two valid words.
        g4 = 4'b0110;
        tick();
        check("mid_pre", 64'(b4), 64'h4);
        rst_n = 1'b0; g4 = 4'b1111;
        tick();
        check("mid_rst_bin", 64'(b4), 64'h0);
        check("mid_rst_ov", 64'(ov4), 64'h0);
        rst_n = 1'b1; g4 = 4'b1000;
        tick();
        check("mid_post_bin", 64'(b4), 64'hF);
        check("mid_post_ov", 64'(ov4), 64'h1);

`ifdef GRAY_TO_BINARY_STEP_CHECK_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dg = '{4'b0000, 4'b0001, 4'b0011, 4'b0110};
        for (int i = 0; i < 4; i++) begin
            g4 = dg[i];
            tick();
            check($sformatf("step_err_%0d", i), 64'(se4), (i == 3) ? 64'h1 : 64'h0);
        end
        g4 = 4'b0110;
        tick();
        check("step_same", 64'(se4), 64'h0);
        iv4 = 1'b0;
        tick();
        check("step_idle", 64'(se4), 64'h0);
        rst_n = 1'b0; iv4 = 1'b1; g4 = 4'b1111;
        tick();
        check("step_rst", 64'(se4), 64'h0);
        rst_n = 1'b1;
        tick();
        check("step_first", 64'(se4), 64'h0);
        g4 = 4'b0000;
        tick();
        check("step_jump", 64'(se4), 64'h1);
`endif
        iv4 = 1'b0;

        // WIDTH=1 passes the bit straight through.
        iv1 = 1'b1; g1 = 1'b1;
        tick();
        check("w1_one", 64'(b1), 64'h1);
        g1 = 1'b0;
        tick();
        check("w1_zero", 64'(b1), 64'h0);
        check("w1_ov", 64'(ov1), 64'h1);
        iv1 = 1'b0;

        // WIDTH=16 all-ones, then random Gray codes of random binary values.
        iv16 = 1'b1; g16 = 16'hFFFF;
        tick();
        check("w16_ones", 64'(b16), 64'hAAAA);
        for (int i = 0; i < 10000; i++) begin
            bv16 = 16'($urandom);
            g16  = bv16 ^ (bv16 >> 1);
            tick();
            check("w16_rand_bin", 64'(b16), 64'(bv16));
            check("w16_rand_ov", 64'(ov16), 64'h1);
        end
        iv16 = 1'b0;
        tick();
        check("w16_idle_ov", 64'(ov16), 64'h0);
        check("w16_idle_bin", 64'(b16), 64'(bv16));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_to_binary.md
Name: gray_to_binary

Overview:
- Registered Gray-code-to-binary converter, parameterizable width.
- Sits on the output side of Gray-coded counters and pointers, for example FIFO pointers after a clock-domain crossing or encoder readouts. Converts each valid Gray word to natural binary with one cycle of latency.
- Single clock domain, no backpressure.

Parameters:
- WIDTH, 4, bit width of the gray and bin words; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low. Sampled on the rising edge of clk.
- in_valid  input  1  qualifies gray on this cycle.
- gray  input  WIDTH  Gray-coded input word.
- out_valid  output  1  bin holds a freshly converted word this cycle.
- bin  output  WIDTH  binary result (registered).

Behaviour:
- Conversion rule:
  - bin[WIDTH-1] = gray[WIDTH-1].
  - bin[i] = bin[i+1] XOR gray[i] for i = WIDTH-2 down to 0.
  - Equivalently, bin[i] is the XOR of gray[WIDTH-1:i].
  - Purely bitwise; no arithmetic carry; no overflow possible.
- Reset: on a rising edge with rst_n=0, bin <= 0 and out_valid <= 0. This applies mid-stream: an accepted word in flight is discarded.
- Latency: exactly 1 cycle. If in_valid=1 at edge N, then at edge N+1 (visible after edge N) out_valid=1 and bin=convert(gray sampled at N).
- Throughput: one word per cycle, back-to-back; no stall input.
- Idle: when in_valid=0, out_valid <= 0 and bin holds its last value, not zeroed.
- Inputs are sampled only at edges; no combinational path from gray to bin.
- Boundary values:
  - WIDTH=1: bin = gray.
  - All-ones input gives alternating 1010... from the MSB.
  - All-zeros input gives all-zeros output.
- X on gray while in_valid=0 must not propagate to bin.

Optional Feature:
- Macro: GRAY_TO_BINARY_STEP_CHECK_EN.
- When defined:
  - Adds output port step_err (1 bit, registered, asserted alongside out_valid).
  - The block keeps the previous accepted gray word plus a flag marking it valid.
  - step_err=1 when the current accepted word differs from the previous accepted word in more than one bit position. This flags a non-monotonic or corrupted Gray sequence.
  - An identical word (0 bits differ) is not an error.
  - The first word after reset is never an error.
  - Reset clears the history flag and step_err.
  - step_err is 0 whenever out_valid=0.
- When undefined: the step_err port, history register and comparison logic are all absent; behaviour is otherwise identical.

Decomposition:
- Package gray_pkg:
  - localparam GRAY_DEFAULT_WIDTH = 4.
  - Pure function gray2bin(logic [63:0], width), usable by testbenches as a reference model.
  - Function popcount for the step check.
- One natural sub-module: gray_prefix_xor, combinational, parameter WIDTH. It implements the MSB-down XOR prefix. gray_to_binary wraps it with the input qualification, output registers and optional checker.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1, gray=4'b1111 -> bin=0000, out_valid=0 throughout. First conversion appears only 1 cycle after release.
- Directed vectors at WIDTH=4, back-to-back with in_valid=1 -> one cycle later:
  - gray 0000 -> bin 0000
  - gray 0110 -> bin 0100
  - gray 1000 -> bin 1111
  - gray 1111 -> bin 1010
  - out_valid stays high for 4 consecutive cycles.
- Exhaustive: all 16 values at WIDTH=4, plus a 10000-sample random run at WIDTH=16 -> every result matches gray2bin, with latency exactly 1.
- Idle hold: convert 1000 (bin 1111), then in_valid=0 with gray=X for 3 cycles -> bin stays 1111, out_valid=0, no X on bin.
- Mid-stream reset: assert rst_n=0 for one edge between two valid words -> bin=0000, out_valid=0 on that cycle. The next valid word converts normally.
- With GRAY_TO_BINARY_STEP_CHECK_EN:
  - Sequence 0000, 0001, 0011, 0110 -> step_err = 0, 0, 0, 1.
  - After reset, first word 1111 -> step_err=0.
